tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/serial_pkg.sv | 15 +
 rtl/tx_arbiter_rr_pick.sv | 36 +++
 rtl/tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: arbiter state encodings and
// the burst-limit constant that means "no forced release".
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_OWN       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_t;

    localparam int MAX_BURST_UNLIMITED = 0;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Round-robin winner selection: searches upward from last_owner+1 with
// wrap-around and returns a one-hot winner plus an any-request flag.
module rr_pick
    import serial_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic [N-1:0]  winner,
    output logic          any
);

    logic [IW-1:0] idx_s;
    logic          found_s;

    // first set request after last_owner, last_owner itself is checked last
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= N; i++) begin
            idx_s = IW'((int'(last_owner) + i) % N);
            if (!found_s && req[idx_s]) begin
                winner[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/tx_arbiter.sv
// Shares one serial_tx among NUM_REQ byte requesters: round-robin ownership,
// one byte in flight at a time, optional burst cap when others are waiting.
module tx_arbiter
    import serial_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_new_data,
    input  logic                 tx_busy
);

    localparam int             IW        = $clog2(NUM_REQ);
    localparam bit             CAP_EN    = (MAX_BURST != MAX_BURST_UNLIMITED);
    localparam int             BW        = CAP_EN ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BW-1:0]  BURST_CAP = BW'(MAX_BURST);
    localparam logic [BW-1:0]  BURST_ONE = BW'(1);
    localparam logic [IW-1:0]  LAST_RST  = IW'(NUM_REQ - 1);

    arb_state_t          state_r;
    logic [NUM_REQ-1:0]  grant_r;
    logic [IW-1:0]       owner_r;
    logic [IW-1:0]       last_owner_r;
    logic [7:0]          tx_data_r;
    logic                tx_new_data_r;
    logic [BW-1:0]       burst_cnt_r;

    logic [NUM_REQ-1:0]  winner_s;
    logic                any_s;
    logic [IW-1:0]       winner_idx_s;
    logic                owner_req_s;
    logic                owner_valid_s;
    logic [7:0]          owner_byte_s;
    logic                others_s;
    logic                at_cap_s;
    logic                cap_release_s;
    logic                done_release_s;
    logic                send_s;

    function automatic logic [IW-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                r = IW'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_r),
        .winner     (winner_s),
        .any        (any_s)
    );

    // owner view of the request bus and the release/send decisions in OWN
    always_comb begin
        winner_idx_s   = onehot_idx(winner_s);
        owner_req_s    = req[owner_r];
        owner_valid_s  = req_valid[owner_r];
        owner_byte_s   = req_data[{owner_r, 3'b000} +: 8];
        others_s       = |(req & ~grant_r);
        at_cap_s       = CAP_EN && (burst_cnt_r == BURST_CAP);
        cap_release_s  = at_cap_s && others_s;
        done_release_s = !owner_req_s && !owner_valid_s;
        send_s         = (state_r == ST_OWN) && !cap_release_s && owner_valid_s && !tx_busy;
        req_ready      = send_s ? grant_r : '0;
    end

    // arbitration and byte hand-off state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            owner_r       <= '0;
            last_owner_r  <= LAST_RST;
            tx_data_r     <= 8'h00;
            tx_new_data_r <= 1'b0;
            burst_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_new_data_r <= 1'b0;
                    if (any_s) begin
                        grant_r     <= winner_s;
                        owner_r     <= winner_idx_s;
                        burst_cnt_r <= '0;
                        state_r     <= ST_OWN;
                    end else begin
                        grant_r <= '0;
                    end
                end
                ST_OWN: begin
                    if (cap_release_s || done_release_s) begin
                        grant_r      <= '0;
                        last_owner_r <= owner_r;
                        state_r      <= ST_IDLE;
                    end else if (send_s) begin
                        tx_data_r     <= owner_byte_s;
                        tx_new_data_r <= 1'b1;
                        state_r       <= ST_LOAD;
                        if (at_cap_s) begin
                            burst_cnt_r <= '0;
                        end
                    end else if (at_cap_s) begin
                        // nobody else waiting: restart the burst window, keep the grant
                        burst_cnt_r <= '0;
                    end
                end
                ST_LOAD: begin
                    tx_new_data_r <= 1'b0;
                    state_r       <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (burst_cnt_r != '1) begin
                            burst_cnt_r <= burst_cnt_r + BURST_ONE;
                        end
                        state_r <= ST_OWN;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    grant_r       <= '0;
                    tx_new_data_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign tx_data     = tx_data_r;
    assign tx_new_data = tx_new_data_r;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter driving a behavioural serial transmitter (4 clocks/bit);
// strobes and decoded line bytes are checked against an expected-order scoreboard.
module tb_tx_arbiter;

    localparam int NR    = 4;
    localparam int MB    = 2;
    localparam int CPB   = 4;
    localparam int DEPTH = 32;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_valid;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic [7:0]        tx_data;
    logic              tx_new_data;
    logic              tx_busy;
    logic              tx_block;
    logic              tx_line;
    logic              ignore_line;

    int checks;
    int errors;

    tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_new_data (tx_new_data),
        .tx_busy     (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural serial transmitter: start bit, 8 data bits LSB first, stop bit
    typedef enum logic [1:0] {M_IDLE, M_START, M_DATA, M_STOP} mstate_t;
    mstate_t    m_st;
    int         m_cnt;
    int         m_bit;
    logic [7:0] m_sh;
    logic       m_busy;
    assign tx_busy = m_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= M_IDLE; m_cnt <= 0; m_bit <= 0; m_sh <= 8'h00;
            m_busy <= 1'b0; tx_line <= 1'b1;
        end else begin
            case (m_st)
                M_IDLE: begin
                    tx_line <= 1'b1;
                    if (tx_block) begin
                        m_busy <= 1'b1;
                    end else begin
                        m_busy <= 1'b0;
                        if (tx_new_data) begin
                            m_sh <= tx_data; m_st <= M_START; m_cnt <= 0; m_busy <= 1'b1;
                        end
                    end
                end
                M_START: begin
                    tx_line <= 1'b0;
                    if (m_cnt == CPB - 1) begin m_cnt <= 0; m_bit <= 0; m_st <= M_DATA; end
                    else m_cnt <= m_cnt + 1;
                end
                M_DATA: begin
                    tx_line <= m_sh[m_bit];
                    if (m_cnt == CPB - 1) begin
                        m_cnt <= 0;
                        if (m_bit == 7) m_st <= M_STOP;
                        else m_bit <= m_bit + 1;
                    end else m_cnt <= m_cnt + 1;
                end
                default: begin
                    tx_line <= 1'b1;
                    if (m_cnt == CPB - 1) begin m_cnt <= 0; m_st <= M_IDLE; end
                    else m_cnt <= m_cnt + 1;
                end
            endcase
        end
    end

    typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;
    typedef struct { logic [1:0] id; logic [7:0] data; logic [NR-1:0] grant_exp; } vec_t;

    exp_t       exp_q[$];
    logic [7:0] line_q[$];
    vec_t       vecs[6];

    logic [7:0] mem [NR][DEPTH];
    int         head [NR];
    int         tail [NR];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req_v, $time);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (oh[i]) r = i;
        return r;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (head[i] < tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(input int id, input logic [7:0] b);
        mem[id][tail[id]] = b;
        tail[id]++;
    endtask

    task automatic expect_byte(input int id, input logic [7:0] b);
        exp_t e;
        e.id = 2'(id);
        e.data = b;
        exp_q.push_back(e);
        line_q.push_back(b);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((pending() || grant != '0 || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, n);
        end
    endtask

    // requester model: each requester holds req while its byte list is non-empty
    initial begin
        logic [NR-1:0] acc;
        for (int i = 0; i < NR; i++) begin head[i] = 0; tail[i] = 0; end
        req = '0; req_valid = '0; req_data = '0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && head[i] < tail[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    req[i] = 1'b1; req_valid[i] = 1'b1; req_data[8*i +: 8] = mem[i][head[i]];
                end else begin
                    req[i] = 1'b0; req_valid[i] = 1'b0;
                end
            end
        end
    end

    // strobe monitor: scoreboard pop, strobe spacing, ready ownership
    initial begin
        logic          prev_s;
        logic [NR-1:0] prev_r;
        exp_t          e;
        prev_s = 1'b0; prev_r = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_s = 1'b0; prev_r = '0;
            end else begin
                if (req_ready != '0) check("ready_owner", 32'(req_ready), 32'(grant));
                if (tx_new_data) begin
                    check("strobe_gap", 32'(prev_s), 32'd0);
                    check("strobe_busy", 32'(tx_busy), 32'd0);
                    check("ready_to_strobe", 32'(prev_r == grant && grant != '0), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_strobe: data %0h with none required", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_owner", 32'(oh_idx(grant)), 32'(e.id));
                        check("strobe_data", 32'(tx_data), 32'(e.data));
                    end
                end
                prev_s = tx_new_data; prev_r = req_ready;
            end
        end
    end

    // serial line decoder
    initial begin
        logic [7:0] b;
        logic       stop_b;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx_line === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx_line;
                end
                repeat (CPB) @(negedge clk);
                stop_b = tx_line;
                if (!ignore_line) begin
                    if (line_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_line_byte: got %0h with none required", b);
                    end else begin
                        check("line_byte", 32'(b), 32'(line_q.pop_front()));
                        check("line_stop", 32'(stop_b), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int bad;
        checks = 0; errors = 0;
        rst = 1'b1; tx_block = 1'b0; ignore_line = 1'b0;
        vecs[0] = '{2'd1, 8'hA5, 4'b0010};
        vecs[1] = '{2'd0, 8'h00, 4'b0001};
        vecs[2] = '{2'd3, 8'hFF, 4'b1000};
        vecs[3] = '{2'd2, 8'h5A, 4'b0100};
        vecs[4] = '{2'd1, 8'h81, 4'b0010};
        vecs[5] = '{2'd0, 8'h7E, 4'b0001};

        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_strobe", 32'(tx_new_data), 32'd0);
        check("rst_txdata", 32'(tx_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single-byte transactions from IDLE
        for (int v = 0; v < 6; v++) begin
            load(int'(vecs[v].id), vecs[v].data);
            expect_byte(int'(vecs[v].id), vecs[v].data);
            n = 0;
            while (tx_new_data !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("first_strobe_latency", 32'(n), 32'd3);
            check("vec_grant", 32'(grant), 32'(vecs[v].grant_exp));
            wait_idle("vec");
        end

        // contention straight after reset: owners 0, 1, 3, two bytes each
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load(0, 8'h11); load(0, 8'h12);
        load(1, 8'h21); load(1, 8'h22);
        load(3, 8'h31); load(3, 8'h32);
        expect_byte(0, 8'h11); expect_byte(0, 8'h12);
        expect_byte(1, 8'h21); expect_byte(1, 8'h22);
        expect_byte(3, 8'h31); expect_byte(3, 8'h32);
        wait_idle("contention");

        // burst cap of 2 while requester 2 waits
        for (int k = 1; k <= 5; k++) load(0, 8'(k));
        load(2, 8'hC1); load(2, 8'hC2);
        expect_byte(0, 8'h01); expect_byte(0, 8'h02);
        expect_byte(2, 8'hC1); expect_byte(2, 8'hC2);
        expect_byte(0, 8'h03); expect_byte(0, 8'h04); expect_byte(0, 8'h05);
        wait_idle("burst");

        // transmitter blocked externally while the owner has data
        tx_block = 1'b1;
        repeat (3) @(negedge clk);
        load(3, 8'h3C);
        expect_byte(3, 8'h3C);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (req_ready != '0 || tx_new_data) bad++;
        end
        check("block_stall", 32'(bad), 32'd0);
        check("block_grant", 32'(grant), 32'b1000);
        tx_block = 1'b0;
        wait_idle("block");

        // asynchronous reset while waiting for the byte to finish
        load(2, 8'h77);
        expect_byte(2, 8'h77);
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_rise", 32'(tx_busy), 32'd1);
        repeat (5) @(negedge clk);
        ignore_line = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        check("async_rst_strobe", 32'(tx_new_data), 32'd0);
        check("async_rst_txdata", 32'(tx_data), 32'd0);
        for (int i = 0; i < NR; i++) head[i] = tail[i];
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        line_q.delete();
        ignore_line = 1'b0;
        load(2, 8'h44); load(0, 8'h55);
        expect_byte(0, 8'h55); expect_byte(2, 8'h44);
        n = 0;
        while (grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_grant", 32'(grant), 32'b0001);
        wait_idle("post_rst");

        repeat (20) @(negedge clk);
        check("strobe_queue_empty", 32'(exp_q.size()), 32'd0);
        check("line_queue_empty", 32'(line_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
